// File: rtl/shift_add_mult_ctrl.sv
// rtl/shift_add_mult_ctrl.sv - shift-add 32x32 unsigned multiply sequencer driving an external adder
module shift_add_mult_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     addIn1,
    output logic [WIDTH-1:0]     addIn2,
    output logic                 addCIn,
    input  logic [WIDTH-1:0]     addSum,
    input  logic                 addCOut
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 last_step;

    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_step) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Adder inputs are held at zero outside RUN so the shared adder stays quiet.
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        addIn1 = '0;
        addIn2 = '0;
        addCIn = 1'b0;
        case (state_q)
            S_RUN: begin
                busy   = 1'b1;
                addIn1 = a_q;
                addIn2 = q_q[0] ? m_q : '0;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // One step is a right shift of {carry, sum, Q}; the carry lands in A's MSB so nothing is lost.
    always_comb begin
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d   = multiplicand;
                    q_d   = multiplier;
                    a_d   = '0;
                    cnt_d = '0;
                end
            end
            S_RUN: begin
                a_d   = {addCOut, addSum[WIDTH-1:1]};
                q_d   = {addSum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    product_d = {a_d, q_d};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule
